// File: rtl/ordena_seq_ctrl.sv
// Sequential odd-even transposition sorter: one shared compare-exchange per clock.
// Optional build macro EARLY_EXIT_EN: finish early once an even+odd phase pair makes no swap.
module ordena_seq_ctrl #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ena,
  input  logic                                cresc_ou_decres,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N*W-1:0]                      desordenado,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N*W-1:0]                      ordenado,
  output logic                                busy,
  output logic [$clog2(N*(N-1)/2+1)-1:0]      n_trocas
);

  localparam int S  = N * (N - 1) / 2;
  localparam int CW = $clog2(S + 1);
  localparam int SW = $clog2(S + 1);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rf [N];
  logic            asc_q;
  logic [SW-1:0]   step_q;
  logic [PW-1:0]   phase_q;
  logic [IW-1:0]   pair_i;
  logic [IW-1:0]   pair_nxt;
  logic [W-1:0]    elem_a, elem_b;
  logic            do_swap, last_step, phase_end, early_done;

  assign pair_nxt  = pair_i + IW'(1);
  assign elem_a    = rf[pair_i];
  assign elem_b    = rf[pair_nxt];
  assign do_swap   = asc_q ? (elem_a > elem_b) : (elem_a < elem_b);
  assign last_step = (step_q == SW'(S - 1));
  // Even phases end at pair (N-2,N-1), odd phases one pair earlier.
  assign phase_end = phase_q[0] ? (int'(pair_i) == N - 3) : (int'(pair_i) == N - 2);

`ifdef EARLY_EXIT_EN
  logic swap_seen;
  assign early_done = phase_q[0] && phase_end && !(swap_seen || do_swap);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ena ? SORT : DONE;
      end
      SORT: begin
        busy = 1'b1;
        if (last_step || early_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) rf[k] <= '0;
      asc_q    <= 1'b0;
      step_q   <= '0;
      phase_q  <= '0;
      pair_i   <= '0;
      n_trocas <= '0;
`ifdef EARLY_EXIT_EN
      swap_seen <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      for (int unsigned k = 0; k < N; k++) rf[k] <= desordenado[k*W +: W];
      asc_q    <= cresc_ou_decres;
      step_q   <= '0;
      phase_q  <= '0;
      pair_i   <= '0;
      n_trocas <= '0;
`ifdef EARLY_EXIT_EN
      swap_seen <= 1'b0;
`endif
    end else if (state_q == SORT) begin
      if (do_swap) begin
        rf[pair_i]   <= elem_b;
        rf[pair_nxt] <= elem_a;
        if (n_trocas != CW'(S)) n_trocas <= n_trocas + CW'(1);
      end
      step_q <= step_q + SW'(1);
      if (phase_end) begin
        phase_q <= phase_q + PW'(1);
        pair_i  <= phase_q[0] ? '0 : IW'(1);
      end else begin
        pair_i  <= pair_i + IW'(2);
      end
`ifdef EARLY_EXIT_EN
      if (phase_end && phase_q[0]) swap_seen <= 1'b0;
      else if (do_swap)            swap_seen <= 1'b1;
`endif
    end
  end

  always_comb begin
    ordenado = '0;
    for (int unsigned k = 0; k < N; k++) ordenado[k*W +: W] = rf[k];
  end

endmodule
